// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the MAC transmit frame scheduler.
// State encoding matches the values seen on debug taps.
package tx_sched_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWaitAck = 3'd1,
        StSend    = 3'd2,
        StDrain   = 3'd3,
        StIfg     = 3'd4
    } tx_state_e;

    localparam int unsigned EthMinLen   = 60;
    localparam int unsigned EthMaxLen   = 1514;
    localparam int unsigned EthJumboLen = 9014;

    // Byte counter wide enough for standard or jumbo frames.
    function automatic int unsigned cnt_width(input bit jumbo);
        return jumbo ? 16 : 11;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the source after the last winner.
// The pointer only moves when the grant is actually taken (en_i).
module rr_arbiter #(
    parameter int unsigned NUM_SRC = 2,
    localparam int unsigned PtrW   = $clog2(NUM_SRC)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [PtrW-1:0]    gnt_idx_o
);

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] idx;
    logic            found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = ptr_q;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            idx = PtrW'((32'(ptr_q) + i) % NUM_SRC);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
        ptr_d = (en_i && found) ? gnt_idx_o : ptr_q;
    end

    // Reset to the highest index so source 0 wins first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= PtrW'(NUM_SRC - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares the byte-wide MAC TX port between NUM_SRC frame sources with per-frame
// round-robin, inter-frame gap, and clean abort on underrun, ack timeout or oversize.
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned IFG_CYCLES  = 12,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned MAX_LEN     = EthMaxLen,
    parameter bit          JUMBO_EN    = 1'b0,
    parameter bit          NO_GEN_CRC  = 1'b0
) (
    input  logic                 tx_clk,
    input  logic                 reset,
    input  logic [8*NUM_SRC-1:0] src_data_i,
    input  logic [NUM_SRC-1:0]   src_valid_i,
    input  logic [NUM_SRC-1:0]   src_last_i,
    output logic [NUM_SRC-1:0]   src_ready_o,
    output logic [7:0]           mac_tx_data_o,
    output logic                 mac_tx_dvld_o,
    input  logic                 mac_tx_ack_i,
    output logic                 conf_tx_en_o,
    output logic                 conf_tx_jumbo_en_o,
    output logic                 conf_tx_no_gen_crc_o,
    output logic [NUM_SRC-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 err_underrun_o,
    output logic                 err_timeout_o,
    output logic                 err_oversize_o
);

    localparam int unsigned PtrW = $clog2(NUM_SRC);
    localparam int unsigned CntW = cnt_width(JUMBO_EN);
    localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned IfgW = $clog2(IFG_CYCLES + 1);

    localparam logic [CntW-1:0] MaxLenC = CntW'(MAX_LEN);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(ACK_TIMEOUT - 1);
    localparam logic [IfgW-1:0] IfgLast = IfgW'(IFG_CYCLES - 1);

    tx_state_e          state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic               dvld_q, dvld_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [PtrW-1:0]    gidx_q, gidx_d;
    logic               last_q, last_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic [IfgW-1:0]    ifg_q, ifg_d;
    logic               under_q, under_d;
    logic               tmo_err_q, tmo_err_d;
    logic               over_q, over_d;
    logic               conf_en_q, conf_jumbo_q, conf_nocrc_q;

    logic [NUM_SRC-1:0] arb_gnt;
    logic [PtrW-1:0]    arb_idx;
    logic               arb_en;
    logic               pop, go_ifg, go_drain;
    logic               cur_valid, cur_last;
    logic [7:0]         cur_data;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .clk_i     (tx_clk),
        .rst_i     (reset),
        .req_i     (src_valid_i),
        .en_i      (arb_en),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    assign cur_valid = src_valid_i[gidx_q];
    assign cur_last  = src_last_i[gidx_q];
    assign cur_data  = src_data_i[{gidx_q, 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        dvld_d      = dvld_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        ifg_d       = ifg_q;
        under_d     = 1'b0;
        tmo_err_d   = 1'b0;
        over_d      = 1'b0;
        src_ready_o = '0;
        arb_en      = 1'b0;
        pop         = 1'b0;
        go_ifg      = 1'b0;
        go_drain    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|src_valid_i) begin
                    arb_en      = 1'b1;
                    src_ready_o = arb_gnt;
                    data_d      = src_data_i[{arb_idx, 3'b000} +: 8];
                    last_d      = src_last_i[arb_idx];
                    grant_d     = arb_gnt;
                    gidx_d      = arb_idx;
                    dvld_d      = 1'b1;
                    cnt_d       = CntW'(1);
                    tmo_d       = '0;
                    state_d     = StWaitAck;
                end
            end
            StWaitAck: begin
                if (mac_tx_ack_i) begin
                    if (last_q) go_ifg = 1'b1;
                    else        pop    = 1'b1;
                end else if (tmo_q == TmoLast) begin
                    tmo_err_d = 1'b1;
                    if (last_q) go_ifg   = 1'b1;
                    else        go_drain = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StSend: begin
                if (last_q) go_ifg = 1'b1;
                else        pop    = 1'b1;
            end
            StDrain: begin
                src_ready_o[gidx_q] = 1'b1;
                if (cur_valid && cur_last) go_ifg = 1'b1;
            end
            StIfg: begin
                if (ifg_q == IfgLast) state_d = StIdle;
                else                  ifg_d   = ifg_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // An oversize byte is taken from the source and dropped; if it was the
        // source's last byte there is nothing left to drain.
        if (pop) begin
            src_ready_o[gidx_q] = 1'b1;
            if (!cur_valid) begin
                under_d  = 1'b1;
                go_drain = 1'b1;
            end else if (cnt_q == MaxLenC) begin
                over_d = 1'b1;
                if (cur_last) go_ifg   = 1'b1;
                else          go_drain = 1'b1;
            end else begin
                data_d  = cur_data;
                last_d  = cur_last;
                cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                state_d = StSend;
            end
        end

        if (go_drain) begin
            state_d = StDrain;
            dvld_d  = 1'b0;
        end
        if (go_ifg) begin
            state_d = StIfg;
            dvld_d  = 1'b0;
            grant_d = '0;
            ifg_d   = '0;
        end
    end

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            data_q       <= '0;
            dvld_q       <= 1'b0;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            ifg_q        <= '0;
            under_q      <= 1'b0;
            tmo_err_q    <= 1'b0;
            over_q       <= 1'b0;
            conf_en_q    <= 1'b0;
            conf_jumbo_q <= 1'b0;
            conf_nocrc_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            dvld_q       <= dvld_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            ifg_q        <= ifg_d;
            under_q      <= under_d;
            tmo_err_q    <= tmo_err_d;
            over_q       <= over_d;
            conf_en_q    <= 1'b1;
            conf_jumbo_q <= JUMBO_EN;
            conf_nocrc_q <= NO_GEN_CRC;
        end
    end

    assign mac_tx_data_o        = data_q;
    assign mac_tx_dvld_o        = dvld_q;
    assign grant_o              = grant_q;
    assign busy_o               = (state_q != StIdle);
    assign err_underrun_o       = under_q;
    assign err_timeout_o        = tmo_err_q;
    assign err_oversize_o       = over_q;
    assign conf_tx_en_o         = conf_en_q;
    assign conf_tx_jumbo_en_o   = conf_jumbo_q;
    assign conf_tx_no_gen_crc_o = conf_nocrc_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: two modelled byte sources and a MAC
// that acks a programmable number of cycles after dvld rises.
module tb_tx_frame_scheduler;

    logic        tx_clk = 1'b0;
    logic        reset  = 1'b1;
    logic [15:0] src_data_i;
    logic [1:0]  src_valid_i, src_last_i, src_ready_o;
    logic [7:0]  mac_tx_data_o;
    logic        mac_tx_dvld_o, mac_tx_ack_i;
    logic        conf_tx_en_o, conf_tx_jumbo_en_o, conf_tx_no_gen_crc_o;
    logic [1:0]  grant_o;
    logic        busy_o, err_underrun_o, err_timeout_o, err_oversize_o;

    always #5 tx_clk = ~tx_clk;

    tx_frame_scheduler #(
        .NUM_SRC     (2),
        .IFG_CYCLES  (12),
        .ACK_TIMEOUT (1024),
        .MAX_LEN     (1514),
        .JUMBO_EN    (1'b0),
        .NO_GEN_CRC  (1'b0)
    ) dut (
        .tx_clk               (tx_clk),
        .reset                (reset),
        .src_data_i           (src_data_i),
        .src_valid_i          (src_valid_i),
        .src_last_i           (src_last_i),
        .src_ready_o          (src_ready_o),
        .mac_tx_data_o        (mac_tx_data_o),
        .mac_tx_dvld_o        (mac_tx_dvld_o),
        .mac_tx_ack_i         (mac_tx_ack_i),
        .conf_tx_en_o         (conf_tx_en_o),
        .conf_tx_jumbo_en_o   (conf_tx_jumbo_en_o),
        .conf_tx_no_gen_crc_o (conf_tx_no_gen_crc_o),
        .grant_o              (grant_o),
        .busy_o               (busy_o),
        .err_underrun_o       (err_underrun_o),
        .err_timeout_o        (err_timeout_o),
        .err_oversize_o       (err_oversize_o)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int s_len[2], s_pos[2], s_frames[2], s_fr[2], s_hold_at[2], s_hold_cyc[2], rdy_cnt[2];
    int ack_delay, rise_cyc, fall_cyc, dvld_hi;
    int n_under, n_tmo, n_over, tmo_cyc, over_cyc;
    bit acked, dvld_prev, under_dvld, over_dvld;
    logic [7:0] outq[$];
    int gq[$];
    int gaps[$];

    function automatic logic [7:0] pat(int s, int f, int p);
        return 8'(s * 100 + f * 17 + p);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        outq.delete();
        gq.delete();
        gaps.delete();
        n_under = 0; n_tmo = 0; n_over = 0;
        tmo_cyc = 0; over_cyc = 0; dvld_hi = 0;
        under_dvld = 1'b1; over_dvld = 1'b1;
        rdy_cnt[0] = 0; rdy_cnt[1] = 0;
        fall_cyc = -1;
    endtask

    task automatic start(int s, int len, int frames);
        s_len[s] = len; s_pos[s] = 0; s_frames[s] = frames;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src_valid_i = '0;
        mac_tx_ack_i = 1'b0;
        for (int s = 0; s < 2; s++) begin
            s_frames[s] = 0; s_pos[s] = 0; s_fr[s] = 0; s_hold_at[s] = -1; s_hold_cyc[s] = 0;
        end
        dvld_prev = 1'b0;
        acked = 1'b0;
        repeat (2) @(negedge tx_clk);
        reset = 1'b0;
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later.
    task automatic step();
        @(negedge tx_clk);
        cyc++;
        if (mac_tx_dvld_o && !dvld_prev) begin
            if (fall_cyc >= 0) gaps.push_back(cyc - fall_cyc);
            rise_cyc = cyc;
            acked = 1'b0;
            gq.push_back(grant_o == 2'b01 ? 0 : (grant_o == 2'b10 ? 1 : -1));
        end
        if (!mac_tx_dvld_o && dvld_prev) fall_cyc = cyc;
        mac_tx_ack_i = mac_tx_dvld_o && !acked && ack_delay >= 0 && (cyc - rise_cyc == ack_delay);
        for (int s = 0; s < 2; s++) begin
            bit hold;
            hold = (s_pos[s] == s_hold_at[s]) && (s_hold_cyc[s] > 0);
            if (hold) s_hold_cyc[s]--;
            src_valid_i[s]       = (s_frames[s] > 0) && !hold;
            src_data_i[8*s +: 8] = pat(s, s_fr[s], s_pos[s]);
            src_last_i[s]        = (s_pos[s] == s_len[s] - 1);
        end
        #1;
        if (mac_tx_dvld_o && (acked || mac_tx_ack_i)) outq.push_back(mac_tx_data_o);
        if (mac_tx_ack_i) acked = 1'b1;
        if (mac_tx_dvld_o) dvld_hi++;
        if (err_underrun_o) begin n_under++; under_dvld = mac_tx_dvld_o; end
        if (err_timeout_o) begin n_tmo++; tmo_cyc = cyc; end
        if (err_oversize_o) begin n_over++; over_cyc = cyc; over_dvld = mac_tx_dvld_o; end
        for (int s = 0; s < 2; s++) begin
            if (src_valid_i[s] && src_ready_o[s]) begin
                rdy_cnt[s]++;
                if (s_pos[s] == s_len[s] - 1) begin
                    s_pos[s] = 0; s_fr[s]++; s_frames[s]--;
                end else begin
                    s_pos[s]++;
                end
            end
        end
        dvld_prev = mac_tx_dvld_o;
    endtask

    task automatic wait_done(string tag, int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = (s_frames[0] == 0) && (s_frames[1] == 0) && !busy_o;
        end
        chk({tag, "_done"}, 32'(done), 1);
    endtask

    initial begin
        int bad, f;
        bit hit;
        src_valid_i = '0; src_last_i = '0; src_data_i = '0; mac_tx_ack_i = 1'b0;
        ack_delay = 0;
        clear_stats();
        do_reset();
        reset = 1'b1;
        #1;
        chk("rst_dvld", 32'(mac_tx_dvld_o), 0);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_conf_en", 32'(conf_tx_en_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        @(negedge tx_clk);
        reset = 1'b0;
        step();
        chk("conf_en", 32'(conf_tx_en_o), 1);
        chk("conf_jumbo", 32'(conf_tx_jumbo_en_o), 0);
        chk("conf_nocrc", 32'(conf_tx_no_gen_crc_o), 0);

        // 1: 60-byte frame, ack 3 cycles after dvld
        clear_stats(); ack_delay = 3;
        start(0, 60, 1);
        wait_done("t1", 200);
        chk("t1_bytes", outq.size(), 60);
        bad = 0;
        foreach (outq[i]) if (outq[i] !== pat(0, 0, i)) bad++;
        chk("t1_order", bad, 0);
        chk("t1_dvld_hi", dvld_hi, 63);
        chk("t1_ready", rdy_cnt[0], 60);
        chk("t1_errs", n_under + n_tmo + n_over, 0);
        chk("t1_grant", gq.size() > 0 ? gq[0] : -2, 0);

        // 2: both sources continuous, 4 x 64 bytes each
        do_reset(); clear_stats(); ack_delay = 2;
        start(0, 64, 4); start(1, 64, 4);
        wait_done("t2", 1500);
        chk("t2_frames", gq.size(), 8);
        bad = 0;
        foreach (gq[i]) if (gq[i] != i % 2) bad++;
        chk("t2_alternate", bad, 0);
        chk("t2_ngaps", gaps.size(), 7);
        bad = 0;
        foreach (gaps[i]) if (gaps[i] != 13) bad++;
        chk("t2_gap13", bad, 0);
        chk("t2_bytes", outq.size(), 512);
        bad = 0;
        foreach (outq[i]) if (outq[i] !== pat((i / 64) % 2, (i / 64) / 2, i % 64)) bad++;
        chk("t2_order", bad, 0);

        // 3: underrun at byte 20 of 60 on src1
        clear_stats(); ack_delay = 0;
        s_hold_at[1] = 20; s_hold_cyc[1] = 3;
        start(1, 60, 1);
        wait_done("t3", 300);
        chk("t3_underrun", n_under, 1);
        chk("t3_dvld_at_err", 32'(under_dvld), 0);
        chk("t3_bytes", outq.size(), 20);
        chk("t3_drained", rdy_cnt[1], 60);
        chk("t3_other_errs", n_tmo + n_over, 0);

        // 4: ack never arrives, then a normal frame from src1
        clear_stats(); ack_delay = -1;
        start(0, 60, 1);
        wait_done("t4", 1300);
        chk("t4_timeout", n_tmo, 1);
        chk("t4_tmo_lat", tmo_cyc - rise_cyc, 1024);
        chk("t4_dvld_hi", dvld_hi, 1024);
        chk("t4_bytes", outq.size(), 0);
        chk("t4_drained", rdy_cnt[0], 60);
        clear_stats(); ack_delay = 1; f = s_fr[1];
        start(1, 10, 1);
        wait_done("t4b", 100);
        chk("t4b_bytes", outq.size(), 10);
        bad = 0;
        foreach (outq[i]) if (outq[i] !== pat(1, f, i)) bad++;
        chk("t4b_order", bad, 0);
        chk("t4b_dvld_hi", dvld_hi, 11);

        // 5: 1600-byte frame against MAX_LEN 1514
        clear_stats(); ack_delay = 0; f = s_fr[0];
        start(0, 1600, 1);
        wait_done("t5", 2000);
        chk("t5_oversize", n_over, 1);
        chk("t5_over_lat", over_cyc - rise_cyc, 1514);
        chk("t5_dvld_at_err", 32'(over_dvld), 0);
        chk("t5_bytes", outq.size(), 1514);
        bad = 0;
        foreach (outq[i]) if (outq[i] !== pat(0, f, i)) bad++;
        chk("t5_order", bad, 0);
        chk("t5_drained", rdy_cnt[0], 1600);

        // 6: reset at byte 30, then both request and src0 must win
        clear_stats(); ack_delay = 0;
        start(1, 60, 1);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            if (outq.size() == 30) hit = 1'b1;
        end
        chk("t6_reach", 32'(hit), 1);
        chk("t6_pre_dvld", 32'(mac_tx_dvld_o), 1);
        #1;
        reset = 1'b1;
        src_valid_i = '0;
        #1;
        chk("t6_dvld", 32'(mac_tx_dvld_o), 0);
        chk("t6_grant", 32'(grant_o), 0);
        chk("t6_conf_en", 32'(conf_tx_en_o), 0);
        chk("t6_busy", 32'(busy_o), 0);
        do_reset();
        step();
        chk("t6_conf_en_after", 32'(conf_tx_en_o), 1);
        clear_stats(); ack_delay = 0;
        start(0, 8, 1); start(1, 8, 1);
        wait_done("t6b", 200);
        chk("t6_first_grant", gq.size() > 0 ? gq[0] : -2, 0);
        chk("t6_second_grant", gq.size() > 1 ? gq[1] : -2, 1);
        chk("t6_bytes", outq.size(), 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
